// File: rtl/mulv_seq_if.sv
// mulv_seq_if: start/done bundle for the bit-sliced sequential multiplier.
// The accum signal exists only when MULV_MAC_EN is defined.
//
// Handshake: a request is accepted on a rising clk edge where start=1 and
// ready=1; a, b (and accum) are sampled on that edge only. ready is high
// exactly while the engine is idle, which includes the cycle in which done
// pulses. done is a one-cycle pulse marking the cycle in which y first
// shows the new result; y holds that value until the next done.
interface mulv_seq_if #(
    parameter int WIDTH_OP = 2,
    parameter int LANES    = 16
);
    logic                          start;
    logic                          ready;
    logic [WIDTH_OP*LANES-1:0]     a;
    logic [WIDTH_OP*LANES-1:0]     b;
`ifdef MULV_MAC_EN
    logic                          accum;
`endif
    logic [2*WIDTH_OP*LANES-1:0]   y;
    logic                          done;
    // Current FSM state, exported for observation.
    logic [0:0]                    dbg_state;

`ifdef MULV_MAC_EN
    modport master (output start, output a, output b, output accum,
                    input ready, input y, input done, input dbg_state);
    modport slave  (input start, input a, input b, input accum,
                    output ready, output y, output done, output dbg_state);
`else
    modport master (output start, output a, output b,
                    input ready, input y, input done, input dbg_state);
    modport slave  (input start, input a, input b,
                    output ready, output y, output done, output dbg_state);
`endif
endinterface

// File: rtl/mulv_seq.sv
// mulv_seq: LANES independent unsigned WIDTH_OP x WIDTH_OP multipliers in
// bit-plane form, one multiplier bit per clock. Operands and result are
// stored as planes: plane k is the LANES-bit word holding bit k of every lane.
// Optional feature: define MULV_MAC_EN to add the accum input, which seeds
// the accumulator with the previous y (result wraps mod 2^(2*WIDTH_OP)).
module mulv_seq #(
    parameter int WIDTH_OP = 2,
    parameter int LANES    = 16
) (
    input  logic        clk,
    input  logic        rst,
    mulv_seq_if.slave   bus
);
    localparam int AW = WIDTH_OP * LANES;
    localparam int YW = 2 * WIDTH_OP * LANES;
    localparam int IW = (WIDTH_OP > 1) ? $clog2(WIDTH_OP) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [IW-1:0]    i;
    logic [AW-1:0]    a_reg;
    logic [AW-1:0]    b_reg;
    logic [YW-1:0]    acc;
    logic [YW-1:0]    y_r;
    logic             done_r;

    logic [LANES-1:0] b_plane;
    logic [AW-1:0]    masked;
    logic [YW-1:0]    pp;
    logic [YW-1:0]    acc_next;
    logic [LANES-1:0] carry;
    logic [LANES-1:0] pa;
    logic [LANES-1:0] pb;

    assign bus.ready     = (state == IDLE);
    assign bus.y         = y_r;
    assign bus.done      = done_r;
    assign bus.dbg_state = state;

    // Partial product for multiplier bit i, shifted up i planes, then a
    // plane-wise ripple add into acc. Lanes never exchange carries; the
    // carry out of the top plane is dropped (wrap-around).
    always_comb begin
        b_plane  = b_reg[int'(i)*LANES +: LANES];
        masked   = '0;
        pp       = '0;
        acc_next = '0;
        carry    = '0;
        pa       = '0;
        pb       = '0;
        for (int k = 0; k < WIDTH_OP; k++) begin
            masked[k*LANES +: LANES] = a_reg[k*LANES +: LANES] & b_plane;
        end
        pp = {{AW{1'b0}}, masked} << (int'(i) * LANES);
        for (int j = 0; j < 2*WIDTH_OP; j++) begin
            pa = acc[j*LANES +: LANES];
            pb = pp[j*LANES +: LANES];
            acc_next[j*LANES +: LANES] = pa ^ pb ^ carry;
            carry = (pa & pb) | (carry & (pa ^ pb));
        end
    end

    // Control FSM: capture on accepted start, step one bit per cycle,
    // publish y and pulse done on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            i      <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            y_r    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                        i     <= '0;
`ifdef MULV_MAC_EN
                        acc   <= bus.accum ? y_r : '0;
`else
                        acc   <= '0;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (i == IW'(WIDTH_OP - 1)) begin
                        y_r    <= acc_next;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        i <= i + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
